// File: rtl/link_flap_monitor_if.sv
// Link-detect monitor signal bundle: debounced level and alarm ack in,
// registered level, edge events, counters and flap alarm out.
interface link_flap_monitor_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             db_in;
  logic             alarm_ack;
  logic             link_up;
  logic             rise_evt;
  logic             fall_evt;
  logic [CNT_W-1:0] up_events;
  logic [CNT_W-1:0] uptime_ticks;
  logic             flap_alarm;

  modport master (
    output db_in, alarm_ack,
    input  link_up, rise_evt, fall_evt, up_events, uptime_ticks, flap_alarm
  );

  modport slave (
    input  db_in, alarm_ack,
    output link_up, rise_evt, fall_evt, up_events, uptime_ticks, flap_alarm
  );
endinterface

// File: rtl/link_flap_monitor.sv
// Tracks the debounced link level: edge events, up-event and uptime counters,
// and a sticky alarm when the link drops too often inside a tick window.
module link_flap_monitor #(
  parameter int unsigned TICK_DIV    = 500000,
  parameter int unsigned FLAP_WINDOW = 100,
  parameter int unsigned FLAP_LIMIT  = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  link_flap_monitor_if.slave bus
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned WIN_W = $clog2(FLAP_WINDOW + 1);
  localparam int unsigned FC_W  = $clog2(FLAP_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rise_c;
  logic             fall_c;
  logic             tick_c;
  logic             alarm_set_c;

  logic [PRE_W-1:0] pre_cnt;
  logic [FC_W-1:0]  fall_cnt;
  logic [FC_W-1:0]  fall_cnt_nxt;
  logic [FC_W-1:0]  fall_sum;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_cnt_nxt;

  logic             link_up_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] up_events_q;
  logic [CNT_W-1:0] uptime_q;
  logic             alarm_q;

  // Link state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DOWN;
    else       state <= state_nxt;
  end

  // Link state transitions and edge strobes
  always_comb begin
    state_nxt = state;
    rise_c    = 1'b0;
    fall_c    = 1'b0;
    case (state)
      DOWN: if (bus.db_in) begin
        state_nxt = UP;
        rise_c    = 1'b1;
      end
      UP: if (!bus.db_in) begin
        state_nxt = DOWN;
        fall_c    = 1'b1;
      end
      default: state_nxt = DOWN;
    endcase
  end

  // Free-running tick prescaler, independent of link activity
  assign tick_c = (pre_cnt == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pre_cnt <= '0;
    else if (tick_c) pre_cnt <= '0;
    else             pre_cnt <= pre_cnt + PRE_W'(1);
  end

  // Window expiry is applied first so a fall sees the already-aged window
  always_comb begin
    fall_cnt_nxt = fall_cnt;
    win_cnt_nxt  = win_cnt;
    fall_sum     = '0;
    alarm_set_c  = 1'b0;
    if ((fall_cnt != '0) && tick_c) begin
      if (win_cnt == WIN_W'(FLAP_WINDOW - 1)) begin
        fall_cnt_nxt = '0;
        win_cnt_nxt  = '0;
      end else begin
        win_cnt_nxt = win_cnt + WIN_W'(1);
      end
    end
    if (fall_c) begin
      if (fall_cnt_nxt == '0) win_cnt_nxt = '0;
      fall_sum = fall_cnt_nxt + FC_W'(1);
      if (fall_sum == FC_W'(FLAP_LIMIT)) begin
        alarm_set_c  = 1'b1;
        fall_cnt_nxt = '0;
        win_cnt_nxt  = '0;
      end else begin
        fall_cnt_nxt = fall_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fall_cnt <= '0;
      win_cnt  <= '0;
    end else begin
      fall_cnt <= fall_cnt_nxt;
      win_cnt  <= win_cnt_nxt;
    end
  end

  // Registered outputs; a new alarm outranks a simultaneous acknowledge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_up_q   <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      up_events_q <= '0;
      uptime_q    <= '0;
      alarm_q     <= 1'b0;
    end else begin
      link_up_q <= (state_nxt == UP);
      rise_q    <= rise_c;
      fall_q    <= fall_c;
      if (rise_c && (up_events_q != CNT_MAX))
        up_events_q <= up_events_q + CNT_W'(1);
      if (rise_c)
        uptime_q <= '0;
      else if ((state == UP) && tick_c && (uptime_q != CNT_MAX))
        uptime_q <= uptime_q + CNT_W'(1);
      alarm_q <= alarm_set_c | (alarm_q & ~bus.alarm_ack);
    end
  end

  assign bus.link_up      = link_up_q;
  assign bus.rise_evt     = rise_q;
  assign bus.fall_evt     = fall_q;
  assign bus.up_events    = up_events_q;
  assign bus.uptime_ticks = uptime_q;
  assign bus.flap_alarm   = alarm_q;

endmodule

// File: tb/tb_link_flap_monitor.sv
// Scoreboard bench for link_flap_monitor: directed db_in/ack sequences push
// hand-computed observations; a negedge monitor pops them on events or probes.
module tb_link_flap_monitor;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned FLAP_WINDOW = 10;
  localparam int unsigned FLAP_LIMIT  = 4;
  localparam int unsigned CNT_W       = 4;

  typedef struct packed {
    logic             link;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] ue;
    logic [CNT_W-1:0] ut;
    logic             al;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic probe = 1'b0;
  int   total = 0;
  int   bad = 0;

  obs_t  exp_q[$];
  string name_q[$];

  link_flap_monitor_if #(.CNT_W(CNT_W)) bus ();

  link_flap_monitor #(
    .TICK_DIV   (TICK_DIV),
    .FLAP_WINDOW(FLAP_WINDOW),
    .FLAP_LIMIT (FLAP_LIMIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Monitor: every event pulse or probe strobe consumes one expectation
  always @(negedge clk) begin
    obs_t  act;
    obs_t  e;
    string nm;
    if (bus.rise_evt || bus.fall_evt || probe) begin
      act.link = bus.link_up;
      act.rise = bus.rise_evt;
      act.fall = bus.fall_evt;
      act.ue   = bus.up_events;
      act.ut   = bus.uptime_ticks;
      act.al   = bus.flap_alarm;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got link=%b rise=%b fall=%b ue=%0d ut=%0d al=%b",
                 act.link, act.rise, act.fall, act.ue, act.ut, act.al);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL %s got link=%b rise=%b fall=%b ue=%0d ut=%0d al=%b want link=%b rise=%b fall=%b ue=%0d ut=%0d al=%b",
                   nm, act.link, act.rise, act.fall, act.ue, act.ut, act.al,
                   e.link, e.rise, e.fall, e.ue, e.ut, e.al);
        end
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string nm, input logic link, input logic rise, input logic fall,
                      input int ue, input int ut, input logic al);
    obs_t e;
    e.link = link;
    e.rise = rise;
    e.fall = fall;
    e.ue   = CNT_W'(ue);
    e.ut   = CNT_W'(ut);
    e.al   = al;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Drive a level change and expect the matching event on the next edge
  task automatic evt(input string nm, input logic lvl, input int ue, input int ut, input logic al);
    bus.db_in = lvl;
    push(nm, lvl, lvl, ~lvl, ue, ut, al);
    wait_edges(1);
  endtask

  // Check the state left by the most recent edge
  task automatic probe_chk(input string nm, input logic link, input int ue, input int ut,
                           input logic al);
    push(nm, link, 1'b0, 1'b0, ue, ut, al);
    probe = 1'b1;
    wait_edges(1);
    probe = 1'b0;
  endtask

  // Assert reset mid-cycle, check outputs cleared at once, then release
  task automatic do_reset(input logic db);
    reset         = 1'b1;
    bus.db_in     = db;
    bus.alarm_ack = 1'b0;
    probe_chk("reset_state", 1'b0, 0, 0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before test end");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.db_in     = 1'b0;
    bus.alarm_ack = 1'b0;
    wait_edges(2);

    // Rise straight out of reset, then an uptime of 5 ticks that holds after the fall
    do_reset(1'b1);
    evt("first_rise", 1'b1, 1, 0, 1'b0);
    wait_edges(19);
    evt("uptime_fall", 1'b0, 1, 5, 1'b0);
    wait_edges(9);
    probe_chk("uptime_hold", 1'b0, 1, 5, 1'b0);

    // Four quick falls raise the alarm on the fourth fall edge; ack clears it
    do_reset(1'b0);
    evt("fl_r1", 1'b1, 1, 0, 1'b0);
    evt("fl_f1", 1'b0, 1, 0, 1'b0);
    evt("fl_r2", 1'b1, 2, 0, 1'b0);
    evt("fl_f2", 1'b0, 2, 1, 1'b0);
    evt("fl_r3", 1'b1, 3, 0, 1'b0);
    evt("fl_f3", 1'b0, 3, 0, 1'b0);
    evt("fl_r4", 1'b1, 4, 0, 1'b0);
    evt("fl_f4_alarm", 1'b0, 4, 1, 1'b1);
    wait_edges(3);
    probe_chk("alarm_sticky", 1'b0, 4, 1, 1'b1);
    bus.alarm_ack = 1'b1;
    wait_edges(1);
    bus.alarm_ack = 1'b0;
    probe_chk("alarm_acked", 1'b0, 4, 1, 1'b0);

    // Second burst with ack coincident with the alarm-setting fall
    evt("co_r1", 1'b1, 5, 0, 1'b0);
    evt("co_f1", 1'b0, 5, 1, 1'b0);
    evt("co_r2", 1'b1, 6, 0, 1'b0);
    evt("co_f2", 1'b0, 6, 0, 1'b0);
    evt("co_r3", 1'b1, 7, 0, 1'b0);
    evt("co_f3", 1'b0, 7, 1, 1'b0);
    evt("co_r4", 1'b1, 8, 0, 1'b0);
    bus.alarm_ack = 1'b1;
    evt("co_f4_set_wins", 1'b0, 8, 0, 1'b1);
    bus.alarm_ack = 1'b0;
    wait_edges(1);
    probe_chk("co_alarm_held", 1'b0, 8, 0, 1'b1);
    bus.alarm_ack = 1'b1;
    wait_edges(1);
    bus.alarm_ack = 1'b0;
    probe_chk("co_alarm_acked", 1'b0, 8, 0, 1'b0);

    // Three falls, window expires, then a fresh window needs four more falls
    do_reset(1'b0);
    evt("ex_r1", 1'b1, 1, 0, 1'b0);
    evt("ex_f1", 1'b0, 1, 0, 1'b0);
    evt("ex_r2", 1'b1, 2, 0, 1'b0);
    evt("ex_f2", 1'b0, 2, 1, 1'b0);
    evt("ex_r3", 1'b1, 3, 0, 1'b0);
    evt("ex_f3", 1'b0, 3, 0, 1'b0);
    wait_edges(39);
    probe_chk("ex_quiet", 1'b0, 3, 0, 1'b0);
    wait_edges(2);
    evt("ex_r4", 1'b1, 4, 0, 1'b0);
    evt("ex_f4_no_alarm", 1'b0, 4, 0, 1'b0);
    evt("ex_r5", 1'b1, 5, 0, 1'b0);
    evt("ex_f5", 1'b0, 5, 1, 1'b0);
    evt("ex_r6", 1'b1, 6, 0, 1'b0);
    evt("ex_f6", 1'b0, 6, 0, 1'b0);
    evt("ex_r7", 1'b1, 7, 0, 1'b0);
    evt("ex_f7_alarm", 1'b0, 7, 1, 1'b1);
    wait_edges(2);
    probe_chk("ex_alarm_hold", 1'b0, 7, 1, 1'b1);

    // Counter saturation: up_events stops at all-ones, uptime saturates too
    do_reset(1'b0);
    for (int i = 1; i <= 16; i++) begin
      evt($sformatf("sat_rise%0d", i), 1'b1, (i > 15) ? 15 : i, 0, (i > 4));
      evt($sformatf("sat_fall%0d", i), 1'b0, (i > 15) ? 15 : i, (i % 2 == 0) ? 1 : 0, (i >= 4));
    end
    evt("sat_long_rise", 1'b1, 15, 0, 1'b1);
    wait_edges(70);
    evt("sat_long_fall", 1'b0, 15, 15, 1'b1);

    // Async reset in the middle of an up period, then rise after release
    evt("mid_rise", 1'b1, 15, 0, 1'b1);
    wait_edges(10);
    do_reset(1'b1);
    evt("post_reset_rise", 1'b1, 1, 0, 1'b0);
    wait_edges(3);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/link_flap_monitor.md
# link_flap_monitor

Downstream consumer of the debounced link-detect level produced by the Ethernet debounce FSM. It registers the clean level and emits one-cycle rise/fall event pulses. It counts link-up events, measures the duration of the current up period in prescaled ticks, and raises a sticky flap alarm with an acknowledge handshake when the link drops too often within a time window. It feeds the link-status register bank and the interrupt controller.

## Interface
Parameters:
- TICK_DIV, 500000: clock cycles per time tick (10 ms at 50 MHz); must be ≥2.
- FLAP_WINDOW, 100: window length in ticks; must be ≥1.
- FLAP_LIMIT, 4: falling edges within the window that trigger the alarm; must be ≥2.
- CNT_W, 16: width of the event and uptime counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- db_in  in  1  debounced link level (1 = link present); already glitch-free, synchronous to clk.
- alarm_ack  in  1  one-cycle acknowledge; clears flap_alarm.
- link_up  out  1  registered db_in.
- rise_evt  out  1  one-cycle pulse, link went up.
- fall_evt  out  1  one-cycle pulse, link went down.
- up_events  out  CNT_W  saturating count of rising edges.
- uptime_ticks  out  CNT_W  ticks elapsed in the current/last up period, saturating.
- flap_alarm  out  1  sticky flap alarm (interrupt request).

## Operation
- Reset values: link_up=0, rise_evt=0, fall_evt=0, up_events=0, uptime_ticks=0, flap_alarm=0. Internal state: FSM=DOWN, prescaler=0, fall_cnt=0, win_cnt=0.
- FSM DOWN/UP mirrors link_up:
  - DOWN→UP when db_in=1: link_up←1, rise_evt←1, up_events+1 (holds at 2^CNT_W−1), uptime_ticks←0.
  - UP→DOWN when db_in=0: link_up←0, fall_evt←1; fall processing below.
  - Otherwise rise_evt/fall_evt←0.
- Prescaler: free-running 0..TICK_DIV−1, wraps to 0. tick=1 in the cycle the prescaler equals TICK_DIV−1. The prescaler is never cleared by link events.
- Uptime: while in UP and tick=1, uptime_ticks+1, saturating at all-ones. In DOWN it holds its last value. It is cleared only on the rise.
- Flap window, evaluated in order within one cycle:
  1. Expiry: if fall_cnt>0 and tick=1: if win_cnt==FLAP_WINDOW−1, then fall_cnt←0 and win_cnt←0; else win_cnt+1.
  2. Fall: on the UP→DOWN transition, using fall_cnt after step 1: if it was 0, win_cnt←0. Then fall_cnt+1. If the result equals FLAP_LIMIT: flap_alarm←1, fall_cnt←0, win_cnt←0.
- Alarm handshake:
  - flap_alarm stays set until alarm_ack=1 is sampled; it clears on that edge.
  - An alarm set condition in the same cycle as alarm_ack wins: flap_alarm stays 1.
  - alarm_ack while flap_alarm=0 has no effect.
  - Falls continue to be counted while the alarm is set.

## Timing
- db_in → link_up, rise_evt/fall_evt, and up_events: 1 cycle latency (all updated on the same edge).
- Event pulses are exactly 1 cycle wide. Back-to-back toggles of db_in on consecutive cycles produce alternating rise/fall pulses on consecutive cycles.
- flap_alarm asserts on the same edge as the fall_evt of the FLAP_LIMIT-th fall.
- The uptime increment for a tick occurring in the rise cycle is lost, because the clear wins.
- Asynchronous reset mid-operation returns every output and internal register to its reset value immediately. After reset release with db_in=1, the first edge produces a rise_evt.

## Test plan
- Reset with db_in=1, release → next edge link_up=1, rise_evt=1 for 1 cycle, up_events=1, uptime_ticks=0.
- TICK_DIV=4, link held up 20 cycles → uptime_ticks=5 (±1 depending on prescaler phase vs. rise, checked against the model); after fall, value holds.
- FLAP_LIMIT=4, FLAP_WINDOW=10, TICK_DIV=4: four falls within 30 cycles → flap_alarm=1 on the 4th fall_evt edge; fall_cnt resets.
- Same setup, three falls, then 11 ticks with no fall, then one fall → no alarm (window expired; new window count=1).
- Alarm set, pulse alarm_ack → flap_alarm=0 next edge. Ack coincident with a new 4th fall → flap_alarm stays 1.
- Force up_events to 0xFFFF via 65535 rises (CNT_W=16), one more rise → stays 0xFFFF. Assert reset mid-uptime → all outputs 0 immediately.
